mux_n_pipe: RTL and testbench

Parametrised N-input, W-bit selector with a registered select and a 2-entry elastic output buffer.
- Replaces the fixed 4:1 5-bit register-address muxes in the multi-cycle datapath (RegDst/write-address path and similar).
- Select is loaded once per instruction phase and held.
- Data is accepted over a valid/ready handshake, and the selected lane is buffered so downstream stalls do not lose words.

---
 rtl/mux_n_pipe_pkg.sv | 21 ++
 rtl/mux_n_pipe_sel_decode.sv | 27 ++
 rtl/mux_n_pipe.sv | 123 ++++++++++++
 tb/tb_mux_n_pipe.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mux_n_pipe_pkg.sv
// Shared datapath constants and helpers for the N-input selector with an elastic output buffer.
package mux_n_pipe_pkg;

  localparam int DEF_W = 5;
  localparam int DEF_N = 4;

  // Number of bits needed to index n lanes
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((32'sd1 <<< r) < n) begin
        r = r + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_n_pipe_sel_decode.sv
// Lane index to one-hot enable decoder; in_range flags indices below N.
module sel_decode
  import mux_n_pipe_pkg::*;
#(
  parameter int N = DEF_N,
  localparam int SW = clog2(N)
) (
  input  logic [SW-1:0] idx,
  output logic [N-1:0]  en,
  output logic          in_range
);

  // One-hot decode; an index at or above N leaves every enable low
  always_comb begin
    en       = {N{1'b0}};
    in_range = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (idx == SW'(i)) begin
        en[i]    = 1'b1;
        in_range = 1'b1;
      end else begin
        en[i]    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N-lane selector with registered select and 2-entry output FIFO.
// Define MUX_N_PIPE_SEL_CHECK_EN to reject out-of-range select loads and pulse sel_err.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N,
  localparam int SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel_ld,
  input  logic [SW-1:0]  sel_in,
  output logic [SW-1:0]  sel_q,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   dout,
  output logic           sel_err
);

  logic [SW-1:0] sel_q_r;
  logic [N-1:0]  en_r;
  logic [N-1:0]  en_in_s;
  logic          in_range_s;
  logic [W-1:0]  lane_s;
  logic [W-1:0]  head_r;
  logic [W-1:0]  tail_r;
  logic [1:0]    count_r;
  logic          push_s;
  logic          pop_s;

  // Decoding happens at load time so the one-hot enable is held next to sel_q
  sel_decode #(.N(N)) u_dec (
    .idx      (sel_in),
    .en       (en_in_s),
    .in_range (in_range_s)
  );

`ifdef MUX_N_PIPE_SEL_CHECK_EN
  logic sel_err_r;

  // Select register; out-of-range loads are dropped and flagged for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q_r   <= {SW{1'b0}};
      en_r      <= {{(N-1){1'b0}}, 1'b1};
      sel_err_r <= 1'b0;
    end else if (sel_ld && in_range_s) begin
      sel_q_r   <= sel_in;
      en_r      <= en_in_s;
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= sel_ld;
    end
  end

  assign sel_err = sel_err_r;
`else
  // Select register; an out-of-range index keeps an all-zero enable so pushed words are 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q_r <= {SW{1'b0}};
      en_r    <= {{(N-1){1'b0}}, 1'b1};
    end else if (sel_ld) begin
      sel_q_r <= sel_in;
      en_r    <= en_in_s & {N{in_range_s}};
    end
  end

  assign sel_err = 1'b0;
`endif

  // AND-OR lane mux driven by the held one-hot enable
  always_comb begin
    lane_s = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      lane_s = lane_s | ({W{en_r[i]}} & din[i*W +: W]);
    end
  end

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Two-entry FIFO kept as head/tail so dout is always a register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 2'd0;
      head_r  <= {W{1'b0}};
      tail_r  <= {W{1'b0}};
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= lane_s;
          end else begin
            tail_r <= lane_s;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        // Simultaneous push/pop only happens at count 1
        2'b11: begin
          head_r <= lane_s;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign sel_q = sel_q_r;
  assign dout  = head_r;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed self-checking bench for mux_n_pipe (N=4 main instance, N=3 instance for the select range check).
module tb_mux_n_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_ld, in_valid, out_ready;
  logic [1:0]  sel_in, sel_q;
  logic [19:0] din;
  logic        in_ready, out_valid, sel_err;
  logic [4:0]  dout;

  logic        sel_ld3, in_valid3, out_ready3;
  logic [1:0]  sel_in3, sel_q3;
  logic [14:0] din3;
  logic        in_ready3, out_valid3, sel_err3;
  logic [4:0]  dout3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_n_pipe #(.W(5), .N(4)) dut (
    .clk(clk), .rst(rst), .sel_ld(sel_ld), .sel_in(sel_in), .sel_q(sel_q),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .sel_err(sel_err)
  );

  mux_n_pipe #(.W(5), .N(3)) dut3 (
    .clk(clk), .rst(rst), .sel_ld(sel_ld3), .sel_in(sel_in3), .sel_q(sel_q3),
    .in_valid(in_valid3), .in_ready(in_ready3), .din(din3),
    .out_valid(out_valid3), .out_ready(out_ready3), .dout(dout3), .sel_err(sel_err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; sel_ld = 1'b0; sel_in = 2'd0; in_valid = 1'b0; out_ready = 1'b0; din = 20'd0;
    sel_ld3 = 1'b0; sel_in3 = 2'd0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    din3 = {5'd8, 5'd6, 5'd4};
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_sel_q", 32'(sel_q), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);

    // basic select: lanes {3,7,11,19}, select lane 2
    din = {5'd19, 5'd11, 5'd7, 5'd3};
    sel_ld = 1'b1; sel_in = 2'd2;
    step();
    sel_ld = 1'b0;
    chk("basic_sel_q", 32'(sel_q), 32'd2);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_dout", 32'(dout), 32'd11);
    out_ready = 1'b1;
    step();
    chk("basic_drain", 32'(out_valid), 32'd0);

    // streaming: one word per cycle, one cycle of latency
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = {5'd0, 5'(i + 1), 5'd31, 5'd31};
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_dout", 32'(dout), 32'(i + 1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", 32'(out_valid), 32'd0);

    // backpressure: two accepts, then full
    out_ready = 1'b0; in_valid = 1'b1;
    din = {5'd0, 5'd20, 5'd0, 5'd0};
    step();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    din = {5'd0, 5'd21, 5'd0, 5'd0};
    step();
    chk("bp_full", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(dout), 32'd20);
    din = {5'd0, 5'd22, 5'd0, 5'd0};
    step();
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_head", 32'(dout), 32'd20);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_pop1_ready", 32'(in_ready), 32'd1);
    chk("bp_pop1_dout", 32'(dout), 32'd21);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // select change coincident with an accept
    sel_ld = 1'b1; sel_in = 2'd1;
    step();
    chk("sim_sel1", 32'(sel_q), 32'd1);
    out_ready = 1'b0;
    din = {5'd25, 5'd0, 5'd9, 5'd0};
    sel_in = 2'd3; in_valid = 1'b1;
    step();
    sel_ld = 1'b0;
    chk("sim_sel3", 32'(sel_q), 32'd3);
    chk("sim_old_lane", 32'(dout), 32'd9);
    step();
    in_valid = 1'b0;
    chk("sim_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("sim_new_lane", 32'(dout), 32'd25);
    chk("sim_sel_err", 32'(sel_err), 32'd0);
    step();
    chk("sim_empty", 32'(out_valid), 32'd0);

    // N=3 instance: valid load, then out-of-range load
    sel_ld3 = 1'b1; sel_in3 = 2'd1;
    step();
    chk("n3_sel1", 32'(sel_q3), 32'd1);
    sel_in3 = 2'd3;
    step();
    sel_ld3 = 1'b0;
`ifdef MUX_N_PIPE_SEL_CHECK_EN
    chk("n3_sel_kept", 32'(sel_q3), 32'd1);
    chk("n3_err_pulse", 32'(sel_err3), 32'd1);
    step();
    chk("n3_err_clear", 32'(sel_err3), 32'd0);
    in_valid3 = 1'b1;
    step();
    in_valid3 = 1'b0;
    chk("n3_push_valid", 32'(out_valid3), 32'd1);
    chk("n3_push_dout", 32'(dout3), 32'd6);
`else
    chk("n3_sel_loaded", 32'(sel_q3), 32'd3);
    chk("n3_no_err", 32'(sel_err3), 32'd0);
    in_valid3 = 1'b1;
    step();
    in_valid3 = 1'b0;
    chk("n3_push_valid", 32'(out_valid3), 32'd1);
    chk("n3_push_zero", 32'(dout3), 32'd0);
    chk("n3_no_err2", 32'(sel_err3), 32'd0);
`endif

    // reset while full
    sel_ld = 1'b1; sel_in = 2'd2;
    step();
    sel_ld = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    din = {5'd0, 5'd17, 5'd0, 5'd0};
    step(); step();
    chk("rf_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0; rst = 1'b1;
    step();
    chk("rf_valid", 32'(out_valid), 32'd0);
    chk("rf_sel_q", 32'(sel_q), 32'd0);
    chk("rf_sel_err", 32'(sel_err3), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    step();
    chk("rf_stay_empty", 32'(out_valid), 32'd0);
    chk("rf_ready", 32'(in_ready), 32'd1);
    step();
    chk("rf_no_stale", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
